first_nios2_system_sysid_arbiter: RTL and testbench
===================================================

# first_nios2_system_sysid_arbiter

Two-master Avalon-MM read arbiter that shares one read-only control slave, such as the system ID slave, between the Nios II data master and a JTAG/debug master. Each master sees a standard Avalon slave with `waitrequest`. The block grants the shared slave round-robin, drives its address for a programmable number of wait cycles, captures `readdata` into a register, and returns it to the granted master. It sits in the system interconnect between the masters and the unmodified combinational slave.

## Interface
Parameters:
- ADDR_W, 1, slave address width
- DATA_W, 32, data width
- SLAVE_LATENCY, 1, cycles the slave address is held before `readdata` is sampled; legal range 1..15

Ports:
- clock  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_read  in  1  master 0 read request
- m0_address  in  ADDR_W  master 0 address
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 read data
- m1_read, m1_address, m1_waitrequest, m1_readdata  same as master 0, for master 1
- s_address  out  ADDR_W  address to the shared slave
- s_readdata  in  DATA_W  combinational slave data
- busy  out  1  high when the state is not IDLE

## Operation
- The state machine has three states: IDLE, WAIT, DONE.
- **IDLE:**
  - If any `mX_read` is high, pick the winner, latch its address into `addr_q`, load `wait_cnt = SLAVE_LATENCY-1`, and go to WAIT.
  - Otherwise stay in IDLE.
- **Winner selection:**
  - If only one master requests, that master wins.
  - If both request, the master not equal to `last_grant` wins.
  - `last_grant` updates on entry to WAIT.
  - `last_grant` resets to 1, so master 0 wins the first tie.
- **WAIT:**
  - `s_address = addr_q`.
  - When `wait_cnt == 0`, capture `s_readdata` into the winner's `readdata` register and go to DONE.
  - Otherwise decrement `wait_cnt`.
- **DONE:**
  - Deassert the winner's `waitrequest` for exactly one cycle. This completes the transfer.
  - Go to IDLE. There is no back-to-back grant from DONE.
- **waitrequest rule:** `mX_waitrequest` = NOT (state == DONE AND grant == X).
  - The non-granted master stays stalled throughout.
- **readdata:** each `mX_readdata` register holds its last captured value until its next capture.
- **Master protocol:** masters hold `read` and `address` stable while `waitrequest` is high (Avalon rule).
  - If `read` drops during WAIT, the transaction still completes and the data is discarded by the master.
  - No error is flagged for this case.
- **s_address:** equals `addr_q` in WAIT and DONE, and 0 in IDLE.

## Timing
- **Reset values:**
  - state = IDLE, `m0_waitrequest` = 1, `m1_waitrequest` = 1.
  - `m0_readdata` = 0, `m1_readdata` = 0, `s_address` = 0, `busy` = 0.
  - `last_grant` = 1, `wait_cnt` = 0.
- **Latency:**
  - `read` is sampled in IDLE at edge N.
  - Data is captured at edge N+SLAVE_LATENCY.
  - `waitrequest` is low during cycle N+SLAVE_LATENCY+1.
  - With the default parameter, a transfer takes 3 cycles and `waitrequest` is low for 1 cycle.
- **Throughput:** one transfer per SLAVE_LATENCY+2 cycles at most.
- **Both masters continuously requesting:** grants alternate 0,1,0,1,… No starvation; worst-case wait is 2·(SLAVE_LATENCY+2) cycles.
- **Request arriving while busy:** it is not sampled until the next IDLE cycle.
- **Reset asserted mid-transfer:**
  - All state returns to reset values immediately (asynchronous).
  - The interrupted transfer does not complete; any master still holding `read` is re-arbitrated after reset release.
- **Reset release:** synchronous deassertion is provided by the system reset synchronizer outside this block.

## Structure
- **Package `first_nios2_system_sysid_arb_pkg`:**
  - State enum: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - Grant index type.
  - Constant `MAX_SLAVE_LATENCY` = 15 and the `wait_cnt` width (4).
- **Sub-module `sysid_rr_pick2`:** combinational round-robin picker with inputs `req[1:0]` and `last_grant`, and outputs `grant` and `valid`. It is instantiated once.
- The top level contains the FSM, counter, address latch and readdata registers.

## Test plan
- **Reset check:** assert reset with no requests → both `waitrequest` = 1, both `readdata` = 0, `busy` = 0, `s_address` = 0.
- **Single master 0 read, address 1:** slave returns 1363709509 at address 1 and 0 at address 0. Required: `m0_waitrequest` low exactly on cycle N+2, `m0_readdata` = 1363709509, `m1_waitrequest` stays 1 throughout.
- **Simultaneous first requests:** m0 and m1 request together, m0 at address 1, m1 at address 0 → m0 is served first (1363709509); m1 is served next with `waitrequest` low at N+5, `m1_readdata` = 0.
- **Continuous contention:** both masters hold `read` for 20 transfers → grants strictly alternate; each master completes 10 transfers.
- **SLAVE_LATENCY = 4:** `readdata` is sampled at N+4 and `waitrequest` is low at N+5. Changing `s_readdata` at N+3 is not captured; changing it at N+4 is.
- **Reset mid-operation:** assert `reset_n` low during WAIT → outputs return to reset values within the same cycle. After release with `m1_read` still high, m1 is re-served normally and `last_grant` is 1, so it is back at its reset value.

Source files
------------

// File: rtl/first_nios2_system_sysid_arb_pkg.sv
// Shared types and constants for the two-master sysid read arbiter.
package first_nios2_system_sysid_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef logic grant_t;

  localparam int MAX_SLAVE_LATENCY = 15;
  localparam int WAIT_CNT_W        = 4;

  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/first_nios2_system_sysid_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the master that did not win last time wins.
module sysid_rr_pick2
  import first_nios2_system_sysid_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last_grant,
  output grant_t     grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) grant = ~last_grant;
    else              grant = req[1];
  end

endmodule

// File: rtl/first_nios2_system_sysid_arbiter.sv
// Two-master Avalon-MM read arbiter in front of one combinational read-only slave.
//   state | meaning
//   IDLE  | no transfer; requests sampled and arbitrated
//   WAIT  | slave address driven, counting down SLAVE_LATENCY cycles
//   DONE  | winner's waitrequest low for one cycle, then back to IDLE
module first_nios2_system_sysid_arbiter
  import first_nios2_system_sysid_arb_pkg::*;
#(
  parameter int ADDR_W        = 1,
  parameter int DATA_W        = 32,
  parameter int SLAVE_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_read,
  input  logic [ADDR_W-1:0] m0_address,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic              m1_read,
  input  logic [ADDR_W-1:0] m1_address,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_readdata,
  output logic              busy
);

  if (SLAVE_LATENCY < 1 || SLAVE_LATENCY > MAX_SLAVE_LATENCY) begin : g_bad_latency
    $error("SLAVE_LATENCY out of range 1..15");
  end

  localparam wait_cnt_t WAIT_LOAD = wait_cnt_t'(SLAVE_LATENCY - 1);

  arb_state_t state;
  grant_t     last_grant;
  wait_cnt_t  wait_cnt;
  grant_t     pick_grant;
  logic       pick_valid;

  sysid_rr_pick2 u_pick (
    .req        ({m1_read, m0_read}),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  // last_grant doubles as the grant of the transfer in flight; s_address is the address latch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      wait_cnt       <= '0;
      s_address      <= '0;
      m0_readdata    <= '0;
      m1_readdata    <= '0;
      m0_waitrequest <= 1'b1;
      m1_waitrequest <= 1'b1;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            last_grant <= pick_grant;
            s_address  <= pick_grant ? m1_address : m0_address;
            wait_cnt   <= WAIT_LOAD;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            if (last_grant) begin
              m1_readdata    <= s_readdata;
              m1_waitrequest <= 1'b0;
            end else begin
              m0_readdata    <= s_readdata;
              m0_waitrequest <= 1'b0;
            end
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DONE: begin
          m0_waitrequest <= 1'b1;
          m1_waitrequest <= 1'b1;
          s_address      <= '0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_first_nios2_system_sysid_arbiter.sv
// Directed bench: per-cycle vector table for the default latency, plus hand sequences for contention, latency 4 and mid-transfer reset.
module tb_first_nios2_system_sysid_arbiter;

  localparam logic [31:0] D1 = 32'd1363709509;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        m0_read, m1_read;
  logic [0:0]  m0_address, m1_address;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [0:0]  s_address;
  logic [31:0] s_readdata;
  logic        busy;

  logic        a0_read, a1_read;
  logic [0:0]  a0_address, a1_address;
  logic        a0_waitrequest, a1_waitrequest;
  logic [31:0] a0_readdata, a1_readdata;
  logic [0:0]  s4_address;
  logic [31:0] s4_readdata;
  logic        busy4;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  assign s_readdata = (s_address == 1'b1) ? D1 : 32'd0;

  first_nios2_system_sysid_arbiter dut1 (
    .clock(clock), .reset_n(reset_n),
    .m0_read(m0_read), .m0_address(m0_address),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_read(m1_read), .m1_address(m1_address),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_readdata(s_readdata), .busy(busy)
  );

  first_nios2_system_sysid_arbiter #(.SLAVE_LATENCY(4)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .m0_read(a0_read), .m0_address(a0_address),
    .m0_waitrequest(a0_waitrequest), .m0_readdata(a0_readdata),
    .m1_read(a1_read), .m1_address(a1_address),
    .m1_waitrequest(a1_waitrequest), .m1_readdata(a1_readdata),
    .s_address(s4_address), .s_readdata(s4_readdata), .busy(busy4)
  );

  typedef struct {
    logic        rst;
    logic        r0;
    logic        ad0;
    logic        r1;
    logic        ad1;
    logic        w0;
    logic        w1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        bsy;
    logic        sa;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    m0_read = 1'b0; m1_read = 1'b0; a0_read = 1'b0; a1_read = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c1, done, prev, who;

    reset_n = 1'b0;
    m0_read = 0; m1_read = 0; m0_address = 0; m1_address = 0;
    a0_read = 0; a1_read = 0; a0_address = 0; a1_address = 0;
    s4_readdata = 32'd0;

    //            rst  r0   a0   r1   a1   w0   w1   d0      d1     busy sa
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,32'd0, 32'd0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,32'd0, 32'd0,1'b1,1'b1};
    vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,D1,    32'd0,1'b1,1'b1};
    vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,D1,    32'd0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,D1,    32'd0,1'b0,1'b0};
    vecs[5]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,32'd0, 32'd0,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,32'd0, 32'd0,1'b1,1'b1};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,D1,    32'd0,1'b1,1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,D1,    32'd0,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,D1,    32'd0,1'b1,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,D1,    32'd0,1'b1,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,D1,    32'd0,1'b0,1'b0};

    tick();
    tick();
    #1;
    chk("reset_m0_wr", {31'd0, m0_waitrequest}, 32'd1);
    chk("reset_m1_wr", {31'd0, m1_waitrequest}, 32'd1);
    chk("reset_m0_rd", m0_readdata, 32'd0);
    chk("reset_m1_rd", m1_readdata, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_saddr", {31'd0, s_address}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      reset_n    = ~vecs[i].rst;
      m0_read    = vecs[i].r0;
      m0_address = vecs[i].ad0;
      m1_read    = vecs[i].r1;
      m1_address = vecs[i].ad1;
      tick();
      chk($sformatf("vec%0d_m0_wr", i), {31'd0, m0_waitrequest}, {31'd0, vecs[i].w0});
      chk($sformatf("vec%0d_m1_wr", i), {31'd0, m1_waitrequest}, {31'd0, vecs[i].w1});
      chk($sformatf("vec%0d_m0_rd", i), m0_readdata, vecs[i].d0);
      chk($sformatf("vec%0d_m1_rd", i), m1_readdata, vecs[i].d1);
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].bsy});
      chk($sformatf("vec%0d_saddr", i), {31'd0, s_address}, {31'd0, vecs[i].sa});
    end
    reset_n = 1'b1;

    // Continuous contention: grants must alternate, starting with master 0.
    do_reset();
    m0_read = 1'b1; m0_address = 1'b1;
    m1_read = 1'b1; m1_address = 1'b0;
    c0 = 0; c1 = 0; done = 0; prev = -1;
    for (int cyc = 0; cyc < 200 && done < 20; cyc++) begin
      tick();
      if (!m0_waitrequest && !m1_waitrequest)
        chk("contention_both_low", 32'd1, 32'd0);
      else if (!m0_waitrequest || !m1_waitrequest) begin
        who = m0_waitrequest ? 1 : 0;
        if (prev < 0) chk("contention_first_winner", who, 32'd0);
        else          chk("contention_alternate", who, 32'(1 - prev));
        if (who == 0) begin
          c0++;
          chk("contention_m0_data", m0_readdata, D1);
        end else begin
          c1++;
          chk("contention_m1_data", m1_readdata, 32'd0);
        end
        prev = who;
        done++;
      end
    end
    chk("contention_total", done, 32'd20);
    chk("contention_m0_count", c0, 32'd10);
    chk("contention_m1_count", c1, 32'd10);
    m0_read = 1'b0; m1_read = 1'b0;
    tick(); tick();

    // SLAVE_LATENCY = 4: only the value present at edge N+4 is captured.
    do_reset();
    s4_readdata = 32'h1111_1111;
    a0_read = 1'b1; a0_address = 1'b1;
    tick();
    chk("lat4_busy_N", {31'd0, busy4}, 32'd1);
    chk("lat4_saddr_N", {31'd0, s4_address}, 32'd1);
    tick();
    chk("lat4_wr_N1", {31'd0, a0_waitrequest}, 32'd1);
    tick();
    chk("lat4_wr_N2", {31'd0, a0_waitrequest}, 32'd1);
    s4_readdata = 32'hBAD0_BAD0;
    tick();
    chk("lat4_wr_N3", {31'd0, a0_waitrequest}, 32'd1);
    chk("lat4_rd_N3", a0_readdata, 32'd0);
    s4_readdata = 32'h600D_600D;
    tick();
    chk("lat4_wr_N4", {31'd0, a0_waitrequest}, 32'd0);
    chk("lat4_rd_N4", a0_readdata, 32'h600D_600D);
    chk("lat4_m1_wr_N4", {31'd0, a1_waitrequest}, 32'd1);
    a0_read = 1'b0;
    tick();
    chk("lat4_wr_N5", {31'd0, a0_waitrequest}, 32'd1);
    chk("lat4_busy_N5", {31'd0, busy4}, 32'd0);
    chk("lat4_rd_hold", a0_readdata, 32'h600D_600D);

    // Reset during WAIT: outputs clear without a clock edge, m1 re-served afterwards.
    do_reset();
    m1_read = 1'b1; m1_address = 1'b1;
    tick();
    chk("midrst_busy_before", {31'd0, busy}, 32'd1);
    chk("midrst_saddr_before", {31'd0, s_address}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_saddr", {31'd0, s_address}, 32'd0);
    chk("midrst_m0_wr", {31'd0, m0_waitrequest}, 32'd1);
    chk("midrst_m1_wr", {31'd0, m1_waitrequest}, 32'd1);
    chk("midrst_m1_rd", m1_readdata, 32'd0);
    chk("midrst_last_grant", {31'd0, dut1.last_grant}, 32'd1);
    reset_n = 1'b1;
    tick();
    chk("midrst_regrant_busy", {31'd0, busy}, 32'd1);
    chk("midrst_regrant_saddr", {31'd0, s_address}, 32'd1);
    tick();
    chk("midrst_m1_wr_done", {31'd0, m1_waitrequest}, 32'd0);
    chk("midrst_m0_wr_done", {31'd0, m0_waitrequest}, 32'd1);
    chk("midrst_m1_rd_done", m1_readdata, D1);
    m1_read = 1'b0;
    tick();
    chk("midrst_idle_busy", {31'd0, busy}, 32'd0);
    chk("midrst_last_grant_after", {31'd0, dut1.last_grant}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
